// File: rtl/param_tournament_predictor.sv
// Tournament branch predictor: gshare global component, two-level local component, per-PC chooser.
// Latency: a prediction is registered one cycle after the request; updates commit at the sampling edge.
// Backpressure: none; requests are dropped while ready=0 (table initialisation sweep after reset).
module param_tournament_predictor #(
    parameter int PC_BITS    = 16,
    parameter int INDEX_BITS = 8,
    parameter int GHIST_BITS = 8,
    parameter int LHIST_BITS = 8,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  predict,
    input  logic [PC_BITS-1:0]    predict_pc,
    input  logic                  update,
    input  logic [PC_BITS-1:0]    update_pc,
    input  logic                  update_taken,
    input  logic                  update_pred,
    input  logic                  update_g_pred,
    input  logic                  update_l_pred,
    input  logic [GHIST_BITS-1:0] update_ghist,
    output logic                  ready,
    output logic                  pred_valid,
    output logic                  prediction,
    output logic                  g_prediction,
    output logic                  l_prediction,
    output logic [GHIST_BITS-1:0] pred_ghist,
    output logic [15:0]           stat_updates,
    output logic [15:0]           stat_mispredicts
);

    localparam int SWEEP_BITS = (INDEX_BITS > LHIST_BITS) ? INDEX_BITS : LHIST_BITS;
    localparam int G_DEPTH    = 1 << INDEX_BITS;
    localparam int L_DEPTH    = 1 << LHIST_BITS;
    localparam logic [CTR_BITS-1:0]   CTR_INIT   = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0]   CTR_MAX    = {CTR_BITS{1'b1}};
    localparam logic [SWEEP_BITS-1:0] SWEEP_LAST = {SWEEP_BITS{1'b1}};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SWEEP_BITS-1:0]   r_sweep_idx;
    logic [SWEEP_BITS-1:0]   w_sweep_nxt;

    logic [CTR_BITS-1:0]     r_gpht    [G_DEPTH];
    logic [CTR_BITS-1:0]     r_chooser [G_DEPTH];
    logic [LHIST_BITS-1:0]   r_lhist   [G_DEPTH];
    logic [CTR_BITS-1:0]     r_lpht    [L_DEPTH];

    logic [GHIST_BITS-1:0]   r_ghr;
    logic                    r_pred_valid;
    logic                    r_prediction;
    logic                    r_g_prediction;
    logic                    r_l_prediction;
    logic [GHIST_BITS-1:0]   r_pred_ghist;
    logic [15:0]             r_stat_updates;
    logic [15:0]             r_stat_mispredicts;

    logic                    w_ready;
    logic                    w_pred_acc;
    logic                    w_upd_acc;
    logic                    w_unused;

    // predict-side lookups
    logic [INDEX_BITS-1:0]   w_p_idx;
    logic [INDEX_BITS-1:0]   w_p_gidx;
    logic [LHIST_BITS-1:0]   w_p_lhist;
    logic [CTR_BITS-1:0]     w_p_gctr;
    logic [CTR_BITS-1:0]     w_p_lctr;
    logic [CTR_BITS-1:0]     w_p_cctr;
    logic                    w_p_g;
    logic                    w_p_l;
    logic                    w_p_final;

    // update-side lookups
    logic [INDEX_BITS-1:0]   w_u_idx;
    logic [INDEX_BITS-1:0]   w_u_gidx;
    logic [LHIST_BITS-1:0]   w_u_lhist;
    logic                    w_u_mispred;

    function automatic logic [CTR_BITS-1:0] f_sat_step(input logic [CTR_BITS-1:0] cur, input logic up);
        if (up) begin
            return (cur == CTR_MAX) ? cur : cur + 1'b1;
        end
        return (cur == '0) ? cur : cur - 1'b1;
    endfunction

    assign w_ready    = (r_state == ST_RUN);
    assign w_pred_acc = predict & w_ready;
    assign w_upd_acc  = update & w_ready;

    // Upper PC bits beyond the index are intentionally not hashed.
    assign w_unused   = ^{predict_pc, update_pc};

    assign w_p_idx    = predict_pc[INDEX_BITS-1:0];
    assign w_p_gidx   = w_p_idx ^ INDEX_BITS'(r_ghr);
    assign w_p_lhist  = r_lhist[w_p_idx];
    assign w_p_gctr   = r_gpht[w_p_gidx];
    assign w_p_lctr   = r_lpht[w_p_lhist];
    assign w_p_cctr   = r_chooser[w_p_idx];
    assign w_p_g      = w_p_gctr[CTR_BITS-1];
    assign w_p_l      = w_p_lctr[CTR_BITS-1];
    assign w_p_final  = w_p_cctr[CTR_BITS-1] ? w_p_g : w_p_l;

    assign w_u_idx     = update_pc[INDEX_BITS-1:0];
    assign w_u_gidx    = w_u_idx ^ INDEX_BITS'(update_ghist);
    assign w_u_lhist   = r_lhist[w_u_idx];
    assign w_u_mispred = (update_taken != update_pred);

    // Next-state logic: sweep every index once, then run forever until reset.
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep_idx;
        case (r_state)
            ST_INIT: begin
                w_sweep_nxt = r_sweep_idx + 1'b1;
                if (r_sweep_idx == SWEEP_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    // State and sweep index registers; reset restarts the full sweep.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_INIT;
            r_sweep_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_idx <= w_sweep_nxt;
        end
    end

    // Table writes: init sweep, then training. Lookups above are combinational on the
    // pre-edge contents, so a same-cycle prediction always sees pre-update values.
    // When one table is shallower than the sweep, its index wraps and rewrites the
    // same init value, which is harmless.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_gpht[r_sweep_idx[INDEX_BITS-1:0]]    <= CTR_INIT;
            r_chooser[r_sweep_idx[INDEX_BITS-1:0]] <= CTR_INIT;
            r_lhist[r_sweep_idx[INDEX_BITS-1:0]]   <= '0;
            r_lpht[r_sweep_idx[LHIST_BITS-1:0]]    <= CTR_INIT;
        end else if (w_upd_acc) begin
            r_gpht[w_u_gidx]   <= f_sat_step(r_gpht[w_u_gidx], update_taken);
            r_lpht[w_u_lhist]  <= f_sat_step(r_lpht[w_u_lhist], update_taken);
            r_lhist[w_u_idx]   <= {w_u_lhist[LHIST_BITS-2:0], update_taken};
            if (update_g_pred != update_l_pred) begin
                r_chooser[w_u_idx] <= f_sat_step(r_chooser[w_u_idx], update_g_pred == update_taken);
            end
        end
    end

    // Global history: misprediction recovery wins over the speculative shift.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ghr <= '0;
        end else if (w_upd_acc && w_u_mispred) begin
            r_ghr <= {update_ghist[GHIST_BITS-2:0], update_taken};
        end else if (w_pred_acc) begin
            r_ghr <= {r_ghr[GHIST_BITS-2:0], w_p_final};
        end
    end

    // Prediction output registers; values hold until the next accepted request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pred_valid   <= 1'b0;
            r_prediction   <= 1'b0;
            r_g_prediction <= 1'b0;
            r_l_prediction <= 1'b0;
            r_pred_ghist   <= '0;
        end else begin
            r_pred_valid <= w_pred_acc;
            if (w_pred_acc) begin
                r_prediction   <= w_p_final;
                r_g_prediction <= w_p_g;
                r_l_prediction <= w_p_l;
                r_pred_ghist   <= r_ghr;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stat_updates     <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_upd_acc) begin
            if (r_stat_updates != 16'hFFFF) begin
                r_stat_updates <= r_stat_updates + 16'd1;
            end
            if (w_u_mispred && (r_stat_mispredicts != 16'hFFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
            end
        end
    end

    assign ready            = w_ready;
    assign pred_valid       = r_pred_valid;
    assign prediction       = r_prediction;
    assign g_prediction     = r_g_prediction;
    assign l_prediction     = r_l_prediction;
    assign pred_ghist       = r_pred_ghist;
    assign stat_updates     = r_stat_updates;
    assign stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_param_tournament_predictor.sv
// Testbench for param_tournament_predictor: reference model plus expected-prediction queue.
// Latency: each request's expectation is popped on the pred_valid that follows it.
// Backpressure: none; requests are only issued once ready is high (except the ignore test).
module tb_param_tournament_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        predict;
    logic [15:0] predict_pc;
    logic        update;
    logic [15:0] update_pc;
    logic        update_taken;
    logic        update_pred;
    logic        update_g_pred;
    logic        update_l_pred;
    logic [7:0]  update_ghist;
    logic        ready;
    logic        pred_valid;
    logic        prediction;
    logic        g_prediction;
    logic        l_prediction;
    logic [7:0]  pred_ghist;
    logic [15:0] stat_updates;
    logic [15:0] stat_mispredicts;

    always #5 clk = ~clk;

    param_tournament_predictor #(
        .PC_BITS(16), .INDEX_BITS(8), .GHIST_BITS(8), .LHIST_BITS(8), .CTR_BITS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .predict(predict), .predict_pc(predict_pc),
        .update(update), .update_pc(update_pc), .update_taken(update_taken),
        .update_pred(update_pred), .update_g_pred(update_g_pred),
        .update_l_pred(update_l_pred), .update_ghist(update_ghist),
        .ready(ready), .pred_valid(pred_valid), .prediction(prediction),
        .g_prediction(g_prediction), .l_prediction(l_prediction),
        .pred_ghist(pred_ghist), .stat_updates(stat_updates),
        .stat_mispredicts(stat_mispredicts)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // reference model state
    typedef struct packed {
        logic       p;
        logic       g;
        logic       l;
        logic [7:0] gh;
    } exp_t;

    logic [1:0] m_g  [256];
    logic [1:0] m_c  [256];
    logic [1:0] m_lp [256];
    logic [7:0] m_lh [256];
    logic [7:0] m_ghr;
    int         m_upd;
    int         m_mis;
    exp_t       q[$];

    function automatic logic [1:0] sat(input logic [1:0] c, input logic up);
        if (up) return (c == 2'd3) ? c : c + 2'd1;
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            m_g[i] = 2'd1; m_c[i] = 2'd1; m_lp[i] = 2'd1; m_lh[i] = 8'd0;
        end
        m_ghr = 8'd0; m_upd = 0; m_mis = 0;
        q.delete();
    endtask

    task automatic idle_inputs();
        predict = 1'b0; predict_pc = 16'd0; update = 1'b0; update_pc = 16'd0;
        update_taken = 1'b0; update_pred = 1'b0; update_g_pred = 1'b0;
        update_l_pred = 1'b0; update_ghist = 8'd0;
    endtask

    // One clock with the current inputs: model predicts (pre-update), then trains, then compare.
    task automatic cycle();
        exp_t       e;
        logic [7:0] pi, gi, ui, lh;
        logic       exp_v;
        e = '0;
        exp_v = predict;
        if (predict) begin
            pi   = predict_pc[7:0];
            gi   = pi ^ m_ghr;
            e.g  = m_g[gi][1];
            e.l  = m_lp[m_lh[pi]][1];
            e.p  = m_c[pi][1] ? e.g : e.l;
            e.gh = m_ghr;
            q.push_back(e);
        end
        if (update) begin
            ui = update_pc[7:0];
            gi = ui ^ update_ghist;
            lh = m_lh[ui];
            m_g[gi]  = sat(m_g[gi], update_taken);
            m_lp[lh] = sat(m_lp[lh], update_taken);
            m_lh[ui] = {lh[6:0], update_taken};
            if (update_g_pred != update_l_pred)
                m_c[ui] = sat(m_c[ui], update_g_pred == update_taken);
            if (m_upd < 65535) m_upd++;
            if (update_taken != update_pred && m_mis < 65535) m_mis++;
        end
        if (update && (update_taken != update_pred))
            m_ghr = {update_ghist[6:0], update_taken};
        else if (predict)
            m_ghr = {m_ghr[6:0], e.p};
        @(posedge clk);
        #1;
        chk("pred_valid", pred_valid, exp_v);
        if (pred_valid && q.size() > 0) begin
            e = q.pop_front();
            chk("prediction", prediction, e.p);
            chk("g_prediction", g_prediction, e.g);
            chk("l_prediction", l_prediction, e.l);
            chk("pred_ghist", pred_ghist, e.gh);
        end
        chk("stat_updates", stat_updates, m_upd);
        chk("stat_mispredicts", stat_mispredicts, m_mis);
    endtask

    task automatic drive_pred(input logic [15:0] pc);
        idle_inputs();
        predict = 1'b1; predict_pc = pc;
        cycle();
        idle_inputs();
    endtask

    task automatic drive_upd(input logic [15:0] pc, input logic t, input logic p,
                             input logic gp, input logic lp, input logic [7:0] gh);
        idle_inputs();
        update = 1'b1; update_pc = pc; update_taken = t; update_pred = p;
        update_g_pred = gp; update_l_pred = lp; update_ghist = gh;
        cycle();
        idle_inputs();
    endtask

    task automatic hold_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b0);
        chk("rst_pred_valid", pred_valid, 1'b0);
        chk("rst_pred_ghist", pred_ghist, 8'h00);
        chk("rst_stat_updates", stat_updates, 16'd0);
        chk("rst_stat_mispredicts", stat_mispredicts, 16'd0);
        reset_n = 1'b1;
        model_reset();
    endtask

    // Count cycles until ready; optionally hammer requests that must be ignored meanwhile.
    task automatic wait_ready(input int exp_cycles, input logic noisy);
        int   n;
        logic seen_valid;
        n = 0;
        seen_valid = 1'b0;
        if (noisy) begin
            predict = 1'b1; predict_pc = 16'h0033;
            update = 1'b1; update_pc = 16'h0044; update_taken = 1'b1;
            update_pred = 1'b0; update_g_pred = 1'b1; update_l_pred = 1'b0;
            update_ghist = 8'h5A;
        end
        while (!ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (pred_valid) seen_valid = 1'b1;
        end
        idle_inputs();
        chk("init_cycles", n, exp_cycles);
        if (noisy) chk("init_ignored_valid", seen_valid, 1'b0);
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;

        // reset, sweep length, requests ignored during sweep
        hold_reset();
        wait_ready(256, 1'b1);

        // fresh tables predict not-taken everywhere
        drive_pred(16'h00AA);
        chk("r20_prediction", prediction, 1'b0);
        chk("r20_g", g_prediction, 1'b0);
        chk("r20_l", l_prediction, 1'b0);
        chk("r20_ghist", pred_ghist, 8'h00);

        // mispredict recovery rebuilds GHR from the snapshot
        drive_upd(16'h0033, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
        drive_pred(16'h0044);
        chk("r21_ghist", pred_ghist, 8'hB5);
        chk("r21_updates", stat_updates, 16'd1);
        chk("r21_mispredicts", stat_mispredicts, 16'd1);
        cycle();
        chk("hold_ghist", pred_ghist, 8'hB5);

        // training both components toward taken
        hold_reset();
        wait_ready(256, 1'b0);
        repeat (3) drive_upd(16'h0010, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10);
        drive_pred(16'h0000);
        chk("r22_g", g_prediction, 1'b1);
        chk("r22_l", l_prediction, 1'b1);
        chk("r22_prediction", prediction, 1'b1);
        chk("r22_mispredicts", stat_mispredicts, 16'd0);

        // chooser moves to global when only global is right
        hold_reset();
        wait_ready(256, 1'b0);
        repeat (2) drive_upd(16'h0020, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
        drive_pred(16'h0020);
        chk("r23_g", g_prediction, 1'b1);
        chk("r23_l", l_prediction, 1'b0);
        chk("r23_prediction", prediction, 1'b1);

        // same-cycle predict and mispredicting update
        hold_reset();
        wait_ready(256, 1'b0);
        predict = 1'b1; predict_pc = 16'h0005;
        update = 1'b1; update_pc = 16'h0005; update_taken = 1'b1; update_pred = 1'b0;
        update_g_pred = 1'b0; update_l_pred = 1'b0; update_ghist = 8'h3C;
        cycle();
        idle_inputs();
        chk("r24_old_ghist", pred_ghist, 8'h00);
        chk("r24_l_pre_update", l_prediction, 1'b0);
        drive_pred(16'h0005);
        chk("r24_recovered", pred_ghist, 8'h79);

        // random traffic against the model
        for (int k = 0; k < 300; k++) begin
            predict       = 1'($urandom_range(0, 1));
            predict_pc    = 16'($urandom_range(0, 63));
            update        = 1'($urandom_range(0, 1));
            update_pc     = 16'($urandom_range(0, 63));
            update_taken  = 1'($urandom_range(0, 1));
            update_pred   = ($urandom_range(0, 3) == 0) ? ~update_taken : update_taken;
            update_g_pred = 1'($urandom_range(0, 1));
            update_l_pred = 1'($urandom_range(0, 1));
            update_ghist  = 8'($urandom_range(0, 255));
            cycle();
        end
        idle_inputs();

        // reset in the middle of the sweep restarts it
        hold_reset();
        repeat (100) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("r25_ready_low", ready, 1'b0);
        reset_n = 1'b1;
        model_reset();
        wait_ready(256, 1'b0);
        drive_pred(16'h0010);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
